// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: word/address types, FSM state
// encoding, requester identifiers and the round-robin pick helper.
package memory_arbiter_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } arb_state_t;

    typedef enum logic {
        PORT_FETCH,
        PORT_DATA
    } port_t;

    // Round-robin between two requesters: a lone request wins outright,
    // a tie goes to the port that did not win last time.
    function automatic port_t rr_pick(input logic f_req, input logic d_req,
                                      input port_t last);
        if (f_req && d_req) return (last == PORT_DATA) ? PORT_FETCH : PORT_DATA;
        return f_req ? PORT_FETCH : PORT_DATA;
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Memory arbiter: shares one Memory (write channel in_*, read channel out_*)
// between the instruction-fetch port (read-only) and the data port
// (read/write). One Memory transaction outstanding at a time, round-robin
// grant, sticky watchdog flag for a transaction that never completes.
//
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   f_addr/f_valid     fetch request;   f_ready/f_data completion + data
//   d_addr/d_wdata/
//   d_we/d_valid       data request;    d_ready/d_rdata completion + data
//   in_addr/in_data/
//   in_valid/in_ready  Memory write channel
//   out_addr/out_valid/
//   out_ready/out_data Memory read channel
//   err                sticky watchdog timeout
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; arbitrate between f_valid and d_valid
// RD    | read granted; out_valid high until out_ready
// WR    | data write granted; in_valid high until in_ready
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    input  logic                  f_valid,
    output logic                  f_ready,
    output logic [DATA_WIDTH-1:0] f_data,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_we,
    input  logic                  d_valid,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] in_addr,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_valid,
    input  logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    arb_state_t    state;
    port_t         last_grant;
    port_t         pick;
    logic [CW-1:0] wd_cnt;

    assign pick = rr_pick(f_valid, d_valid, last_grant);

    // Completion pulses follow Memory's acknowledge in the same cycle; the
    // acknowledge only counts in the matching state, so strays are ignored.
    assign f_ready = (state == RD) && (last_grant == PORT_FETCH) && out_ready;
    assign d_ready = ((state == RD) && (last_grant == PORT_DATA) && out_ready) ||
                     ((state == WR) && in_ready);
    assign f_data  = out_data;
    assign d_rdata = out_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= PORT_DATA;
            in_addr    <= '0;
            in_data    <= '0;
            in_valid   <= 1'b0;
            out_addr   <= '0;
            out_valid  <= 1'b0;
            wd_cnt     <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_valid || d_valid) begin
                        last_grant <= pick;
                        wd_cnt     <= '0;
                        if (pick == PORT_FETCH) begin
                            out_addr  <= f_addr;
                            out_valid <= 1'b1;
                            state     <= RD;
                        end else if (d_we) begin
                            in_addr  <= d_addr;
                            in_data  <= d_wdata;
                            in_valid <= 1'b1;
                            state    <= WR;
                        end else begin
                            out_addr  <= d_addr;
                            out_valid <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR: begin
                    if (in_ready) begin
                        in_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Watchdog: err lands on the same edge the count reaches TIMEOUT;
            // the transaction keeps waiting and the count saturates.
            if (state != IDLE) begin
                if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one Memory instance (separate write channel `in_*` and read channel `out_*`, valid/ready handshake) between two requesters: the instruction-fetch port (read-only) and the data port (read/write).
- Serialises all traffic, with at most one Memory transaction outstanding.
- Fair round-robin grant between the two ports.
- Sticky watchdog flag reports a Memory transaction that never completes.
- Sits between the core pipeline and Memory.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- TIMEOUT, 1024, cycles a granted transaction may wait for Memory ready before `err` sets; 0 disables the watchdog

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset: the block resets on a rising clk edge while reset==0
- f_addr  in  ADDR_WIDTH  fetch read address
- f_valid  in  1  fetch request
- f_ready  out  1  fetch completion pulse; f_data valid in the same cycle
- f_data  out  DATA_WIDTH  fetch read data
- d_addr  in  ADDR_WIDTH  data-port address
- d_wdata  in  DATA_WIDTH  data-port write data
- d_we  in  1  1 = write, 0 = read
- d_valid  in  1  data-port request
- d_ready  out  1  data-port completion pulse
- d_rdata  out  DATA_WIDTH  data-port read data, valid with d_ready on reads
- in_addr, in_data  out  ADDR_WIDTH/DATA_WIDTH  Memory write address and data
- in_valid  out  1  Memory write request
- in_ready  in  1  Memory write acknowledge
- out_addr  out  ADDR_WIDTH  Memory read address
- out_valid  out  1  Memory read request
- out_ready  in  1  Memory read acknowledge, with out_data
- out_data  in  DATA_WIDTH  Memory read data
- err  out  1  sticky watchdog timeout flag

Behaviour:
- **Reset values:**
  - state IDLE
  - f_ready, d_ready, in_valid, out_valid, err = 0
  - in_addr, in_data, out_addr = 0
  - last_grant = DATA, so fetch wins the first tie
  - watchdog counter = 0
- **Requester rules:**
  - addr, wdata and we are held stable while valid=1 and ready=0.
  - ready is a one-cycle pulse.
  - The requester may keep valid high after ready to issue its next request.
- **FSM:** IDLE, RD, WR.
- **IDLE:**
  - Sample f_valid and d_valid.
  - Neither set: stay in IDLE.
  - One set: grant it.
  - Both set: grant the port opposite to last_grant.
  - On grant, register the address (and wdata for writes) into the out_addr or in_addr/in_data registers.
  - Set last_grant to the granted port.
  - Go to RD (fetch, or data with d_we=0) or WR (data with d_we=1).
- **RD:**
  - out_valid=1 while in RD, driven from registers.
  - When out_ready=1, pulse the granted port's ready in that same cycle.
  - Pass out_data combinationally to f_data or d_rdata.
  - Return to IDLE at the next edge; out_valid is 0 from that edge.
- **WR:**
  - in_valid=1 while in WR.
  - When in_ready=1, pulse d_ready the same cycle and return to IDLE.
- **Latency:** the minimum request-to-ready latency is 1 cycle (request sampled at edge N, Memory ready in cycle N+1). The IDLE cycle between back-to-back grants guarantees Memory sees valid drop between transactions.
- **Exclusivity:** the ungranted port's ready stays 0 until it is granted. in_valid and out_valid are never 1 simultaneously.
- **Stray acknowledges:**
  - out_ready while not in RD, and in_ready while not in WR, are ignored.
  - f_data and d_rdata are don't-care whenever their ready=0.
- **Watchdog:**
  - The counter clears on entry to RD or WR and increments each cycle in RD or WR.
  - When it reaches TIMEOUT (TIMEOUT≠0), err is set; err is cleared only by reset.
  - The transaction continues waiting; it is not aborted.
  - The counter saturates and does not wrap.
- **Reset mid-transaction:** reset==0 at any edge forces every reset value above. Any partial transaction is dropped with no ready pulse; Memory is reset by the same reset.
- **Request withdrawal:** a requester dropping valid before ready is illegal. The arbiter completes the transaction anyway and emits the ready pulse.

Decomposition:
- Shared core package holds:
  - addr_t and word_t (32-bit logic vectors)
  - enum arb_state_t {IDLE, RD, WR}
  - enum port_t {PORT_FETCH, PORT_DATA}
- No sub-module: the round-robin pick is a two-line function and the watchdog is a single counter; both live inline.

Test Plan:
- Single fetch, then single data write: f_addr=36, f_valid=1 → f_ready and f_data=0xefefefef at the first cycle Memory asserts out_ready. d_addr=40, d_we=1, d_wdata=0xc3c3c3c3 → d_ready when in_ready; a later data read of 40 returns 0xc3c3c3c3.
- Contention: f_valid and d_valid held high together for 4 transactions → grants alternate F, D, F, D (fetch first after reset). No ready overlap. in_valid and out_valid never both 1.
- Write-then-read ordering on the data port: write 0x87654321 to 0x10, then immediately read 0x10 → d_rdata=0x87654321.
- Back-to-back fetch with valid held through ready → at least one cycle with out_valid=0 between the two Memory reads. Second f_ready returns data for the new address.
- Watchdog with TIMEOUT=8 and Memory stubbed to never assert out_ready → err rises exactly 8 cycles after RD entry and stays 1. reset=0 for one edge → err=0, state IDLE, out_valid=0.
- Reset mid-write: assert reset=0 while in WR → in_valid=0 after that edge, no d_ready pulse. The next request after reset is served normally, with fetch winning the first tie.
